app_axi_slave_regfile: RTL and testbench
========================================

APP_AXI_SLAVE_REGFILE -- requirements
Module: app_axi_slave_regfile

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, AXI4-Lite data width in bits (a multiple of 8).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, AXI4-Lite address width in bits.
REQ-003 The block SHALL have parameter NUM_REGS, default 16, number of DATA_WIDTH-bit registers (power of 2, >=2).
REQ-004 The block SHALL have port aclk  input  1  the single clock, rising edge.
REQ-005 The block SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have AW ports: awaddr input ADDR_WIDTH; awvalid input 1; awready output 1.
REQ-007 The block SHALL have W ports: wdata input DATA_WIDTH; wstrb input DATA_WIDTH/8; wvalid input 1; wready output 1.
REQ-008 The block SHALL have B ports: bresp output 2; bvalid output 1; bready input 1.
REQ-009 The block SHALL have AR ports: araddr input ADDR_WIDTH; arvalid input 1; arready output 1.
REQ-010 The block SHALL have R ports: rdata output DATA_WIDTH; rresp output 2; rvalid output 1; rready input 1.

Function
REQ-011 Register index SHALL be addr[ADDR_LSB +: log2(NUM_REGS)], with ADDR_LSB = log2(DATA_WIDTH/8); bits below ADDR_LSB are ignored.
REQ-012 An address SHALL be in range iff (addr >> ADDR_LSB) < NUM_REGS; otherwise it is out of range.
REQ-013 The write FSM SHALL have states WR_IDLE, WR_ADDR (address held), WR_DATA (data held) and WR_RESP (bvalid high).
REQ-014 awready SHALL be 1 in WR_IDLE and WR_DATA only; wready SHALL be 1 in WR_IDLE and WR_ADDR only; both are decoded from state.
REQ-015 In WR_IDLE: AW and W handshake in the same cycle -> perform write, go WR_RESP; AW only -> latch awaddr, go WR_ADDR; W only -> latch wdata/wstrb, go WR_DATA.
REQ-016 In WR_ADDR, a W handshake SHALL perform the write and go to WR_RESP; in WR_DATA, an AW handshake SHALL do the same.
REQ-017 The write SHALL update byte lane i of the indexed register only where wstrb[i]=1, at the same clock edge as the completing handshake.
REQ-018 An out-of-range write SHALL modify no register.
REQ-019 In WR_RESP: bvalid=1, bresp=2'b00 (OKAY) for in-range and 2'b10 (SLVERR) for out-of-range; on bready go to WR_IDLE; bvalid/bresp held stable until accepted.
REQ-020 The read FSM SHALL have states RD_IDLE (arready=1, rvalid=0) and RD_RESP (arready=0, rvalid=1).
REQ-021 An AR handshake in RD_IDLE SHALL register rdata = indexed register (0 if out of range) and rresp = OKAY/SLVERR, then go to RD_RESP; rvalid rises the next cycle.
REQ-022 In RD_RESP, rdata/rresp SHALL stay stable; on rready go to RD_IDLE.
REQ-023 Read and write paths SHALL be independent and may complete in the same cycle.
REQ-024 A read captured in the same cycle as a write to the same register SHALL return the pre-write value.
REQ-025 Throughput SHALL be one write per 2 cycles and one read per 2 cycles with bready=rready=1.
REQ-026 The block SHALL never issue bvalid or rvalid without a preceding accepted request.

Reset
REQ-027 While aresetn=0: all registers=0, both FSMs in their IDLE states, bvalid=rvalid=0, bresp=rresp=0, rdata=0, latched addr/data/strb=0.
REQ-028 Reset asserted mid-transaction SHALL discard any held AW/W/pending response; no write completes after reset.
REQ-029 After aresetn deasserts, awready=wready=arready=1 from the first clock.

Verification
REQ-030 AW 0x04 and W 0xDEADBEEF, wstrb 0xF same cycle -> bvalid next cycle, bresp 00; then AR 0x04 -> rdata 0xDEADBEEF, rresp 00.
REQ-031 W 0x11223344 first, AW 0x08 three cycles later -> awready=1/wready=0 in WR_DATA; write on AW; bvalid next cycle; reg2 = 0x11223344.
REQ-032 reg3=0xAABBCCDD, write 0x00000000 with wstrb 0x5 to 0x0C -> read returns 0xAA00CC00.
REQ-033 Write and read to 0x40 (NUM_REGS=16) -> bresp 10, rresp 10, rdata 0, all registers unchanged.
REQ-034 Hold bready=0 and rready=0 for 5 cycles -> bvalid/rvalid, bresp/rresp, rdata stable; awready=wready=arready=0 throughout.
REQ-035 Assert aresetn=0 while in WR_ADDR and RD_RESP -> all valids 0 immediately, FSMs IDLE; reads after release return 0.

Source files
------------

// File: rtl/app_axi_slave_regfile_if.sv
// AXI4-Lite channel bundle between a bus master and the register file slave.
interface app_axi_slave_regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/app_axi_slave_regfile.sv
// AXI4-Lite slave exposing NUM_REGS byte-strobed registers with independent read/write FSMs.
//
// state   | meaning
// WR_IDLE | no write in flight, accepts AW and W
// WR_ADDR | address held, waiting for W
// WR_DATA | data/strobe held, waiting for AW
// WR_RESP | write done, bvalid high until bready
// RD_IDLE | no read in flight, accepts AR
// RD_RESP | rdata/rresp held, rvalid high until rready
module app_axi_slave_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input logic aclk,
  input logic aresetn,
  app_axi_slave_regfile_if.slave axi
);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic [1:0]            bresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic                  awready_c, wready_c, bvalid_c;
  logic                  latch_addr, latch_data, do_write;
  logic [ADDR_WIDTH-1:0] wr_addr_sel;
  logic [DATA_WIDTH-1:0] wr_data_sel;
  logic [STRB_W-1:0]     wr_strb_sel;
  logic                  arready_c, rvalid_c, do_read;

  logic [ADDR_WIDTH-1:0] wr_word, rd_word;
  logic                  wr_in_range, rd_in_range;
  logic [IDX_W-1:0]      wr_idx, rd_idx;

  // Write completes from whichever side arrives last; the other side comes from the holding regs.
  always_comb begin
    wr_state_nxt = wr_state;
    awready_c    = 1'b0;
    wready_c     = 1'b0;
    bvalid_c     = 1'b0;
    latch_addr   = 1'b0;
    latch_data   = 1'b0;
    do_write     = 1'b0;
    wr_addr_sel  = aw_addr_q;
    wr_data_sel  = w_data_q;
    wr_strb_sel  = w_strb_q;
    case (wr_state)
      WR_IDLE: begin
        awready_c = 1'b1;
        wready_c  = 1'b1;
        if (axi.awvalid && axi.wvalid) begin
          do_write     = 1'b1;
          wr_addr_sel  = axi.awaddr;
          wr_data_sel  = axi.wdata;
          wr_strb_sel  = axi.wstrb;
          wr_state_nxt = WR_RESP;
        end else if (axi.awvalid) begin
          latch_addr   = 1'b1;
          wr_state_nxt = WR_ADDR;
        end else if (axi.wvalid) begin
          latch_data   = 1'b1;
          wr_state_nxt = WR_DATA;
        end
      end
      WR_ADDR: begin
        wready_c = 1'b1;
        if (axi.wvalid) begin
          do_write     = 1'b1;
          wr_data_sel  = axi.wdata;
          wr_strb_sel  = axi.wstrb;
          wr_state_nxt = WR_RESP;
        end
      end
      WR_DATA: begin
        awready_c = 1'b1;
        if (axi.awvalid) begin
          do_write     = 1'b1;
          wr_addr_sel  = axi.awaddr;
          wr_state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        bvalid_c = 1'b1;
        if (axi.bready) wr_state_nxt = WR_IDLE;
      end
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_state_nxt = rd_state;
    arready_c    = 1'b0;
    rvalid_c     = 1'b0;
    do_read      = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        arready_c = 1'b1;
        if (axi.arvalid) begin
          do_read      = 1'b1;
          rd_state_nxt = RD_RESP;
        end
      end
      RD_RESP: begin
        rvalid_c = 1'b1;
        if (axi.rready) rd_state_nxt = RD_IDLE;
      end
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  // Range check uses the whole word address so high address bits cannot alias onto a register.
  assign wr_word     = wr_addr_sel >> ADDR_LSB;
  assign rd_word     = axi.araddr >> ADDR_LSB;
  assign wr_in_range = wr_word < ADDR_WIDTH'(NUM_REGS);
  assign rd_in_range = rd_word < ADDR_WIDTH'(NUM_REGS);
  assign wr_idx      = wr_word[IDX_W-1:0];
  assign rd_idx      = rd_word[IDX_W-1:0];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state  <= WR_IDLE;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_state <= wr_state_nxt;
      if (latch_addr) aw_addr_q <= axi.awaddr;
      if (latch_data) begin
        w_data_q <= axi.wdata;
        w_strb_q <= axi.wstrb;
      end
      if (do_write) begin
        bresp_q <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
        if (wr_in_range) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb_sel[b]) regs[wr_idx][b*8 +: 8] <= wr_data_sel[b*8 +: 8];
          end
        end
      end
    end
  end

  // Sampled with the pre-edge register contents, so a same-cycle write is not visible here.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state <= RD_IDLE;
      rdata_q  <= '0;
      rresp_q  <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      if (do_read) begin
        rdata_q <= rd_in_range ? regs[rd_idx] : '0;
        rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign axi.awready = awready_c;
  assign axi.wready  = wready_c;
  assign axi.bvalid  = bvalid_c;
  assign axi.bresp   = bresp_q;
  assign axi.arready = arready_c;
  assign axi.rvalid  = rvalid_c;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
endmodule

// File: tb/tb_app_axi_slave_regfile.sv
// Randomized self-checking bench for app_axi_slave_regfile against an array model of the register map.
module tb_app_axi_slave_regfile;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 16;

  logic aclk;
  logic aresetn;
  int   checks = 0;
  int   errors = 0;
  logic [DW-1:0] model [NR];

  app_axi_slave_regfile_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axi ();

  app_axi_slave_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .axi     (axi.slave)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic bit in_range(input logic [AW-1:0] a);
    return (a / 4) < NR;
  endfunction

  function automatic int idx_of(input logic [AW-1:0] a);
    return int'((a / 4) % NR);
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    return in_range(a) ? model[idx_of(a)] : '0;
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    logic [DW-1:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if (in_range(a)) model[idx_of(a)] = (model[idx_of(a)] & ~mask) | (d & mask);
  endtask

  // mode 0: AW+W together, 1: AW first, 2: W first; gap = idle cycles between the two halves
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                          input int mode, input int gap, input int bhold);
    logic [1:0] exp_resp;
    exp_resp = in_range(a) ? 2'b10 ^ 2'b10 : 2'b10;
    checks++;
    if ({axi.awready, axi.wready} !== 2'b11) begin
      errors++;
      $display("FAIL wr_idle_ready got %b exp 11", {axi.awready, axi.wready});
    end
    if (mode == 0) begin
      axi.awaddr = a; axi.wdata = d; axi.wstrb = s;
      axi.awvalid = 1'b1; axi.wvalid = 1'b1;
      tick();
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    end else if (mode == 1) begin
      axi.awaddr = a; axi.awvalid = 1'b1;
      tick();
      axi.awvalid = 1'b0; axi.awaddr = $urandom;
      repeat (gap) tick();
      checks++;
      if ({axi.awready, axi.wready, axi.bvalid} !== 3'b010) begin
        errors++;
        $display("FAIL wr_addr_held got %b exp 010", {axi.awready, axi.wready, axi.bvalid});
      end
      axi.wdata = d; axi.wstrb = s; axi.wvalid = 1'b1;
      tick();
      axi.wvalid = 1'b0; axi.wdata = $urandom; axi.wstrb = 4'($urandom);
    end else begin
      axi.wdata = d; axi.wstrb = s; axi.wvalid = 1'b1;
      tick();
      axi.wvalid = 1'b0; axi.wdata = $urandom; axi.wstrb = 4'($urandom);
      repeat (gap) tick();
      checks++;
      if ({axi.awready, axi.wready, axi.bvalid} !== 3'b100) begin
        errors++;
        $display("FAIL wr_data_held got %b exp 100", {axi.awready, axi.wready, axi.bvalid});
      end
      axi.awaddr = a; axi.awvalid = 1'b1;
      tick();
      axi.awvalid = 1'b0; axi.awaddr = $urandom;
    end
    model_write(a, d, s);
    checks++;
    if ({axi.bvalid, axi.bresp} !== {1'b1, exp_resp}) begin
      errors++;
      $display("FAIL bresp addr %h got bvalid/bresp %b exp %b", a, {axi.bvalid, axi.bresp}, {1'b1, exp_resp});
    end
    repeat (bhold) begin
      tick();
      checks++;
      if ({axi.bvalid, axi.bresp, axi.awready, axi.wready} !== {1'b1, exp_resp, 2'b00}) begin
        errors++;
        $display("FAIL b_hold got %b exp %b", {axi.bvalid, axi.bresp, axi.awready, axi.wready},
                 {1'b1, exp_resp, 2'b00});
      end
    end
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    checks++;
    if (axi.bvalid !== 1'b0) begin
      errors++;
      $display("FAIL b_release got bvalid %b exp 0", axi.bvalid);
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int rhold);
    logic [DW-1:0] exp_data;
    logic [1:0]    exp_resp;
    exp_data = model_read(a);
    exp_resp = in_range(a) ? 2'b00 : 2'b10;
    checks++;
    if (axi.arready !== 1'b1) begin
      errors++;
      $display("FAIL rd_idle_ready got %b exp 1", axi.arready);
    end
    axi.araddr = a; axi.arvalid = 1'b1;
    tick();
    axi.arvalid = 1'b0; axi.araddr = $urandom;
    for (int i = 0; i <= rhold; i++) begin
      checks++;
      if ({axi.rvalid, axi.arready, axi.rresp, axi.rdata} !== {2'b10, exp_resp, exp_data}) begin
        errors++;
        $display("FAIL rdata addr %h got v/rdy/resp/data %b/%b/%b/%h exp 1/0/%b/%h",
                 a, axi.rvalid, axi.arready, axi.rresp, axi.rdata, exp_resp, exp_data);
      end
      if (i < rhold) tick();
    end
    axi.rready = 1'b1;
    tick();
    axi.rready = 1'b0;
    checks++;
    if (axi.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL r_release got rvalid %b exp 0", axi.rvalid);
    end
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < NR; i++) do_read(AW'(i * 4), 0);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    repeat (3) tick();
    checks++;
    if ({axi.bvalid, axi.rvalid, axi.bresp, axi.rresp, axi.rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got bv %b rv %b bresp %b rresp %b rdata %h exp all 0",
               axi.bvalid, axi.rvalid, axi.bresp, axi.rresp, axi.rdata);
    end
    aresetn = 1'b1;
    tick();
    checks++;
    if ({axi.awready, axi.wready, axi.arready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_ready got %b exp 111", {axi.awready, axi.wready, axi.arready});
    end
  endtask

  task automatic test_basic();
    do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(32'h04, 0);
  endtask

  task automatic test_w_first();
    do_write(32'h08, 32'h11223344, 4'hF, 2, 2, 1);
    do_read(32'h08, 1);
    do_write(32'h24, 32'hCAFEF00D, 4'hF, 1, 3, 0);
    do_read(32'h24, 0);
  endtask

  task automatic test_strobe();
    do_write(32'h0C, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    do_write(32'h0C, 32'h00000000, 4'h5, 0, 0, 0);
    checks++;
    if (model[3] !== 32'hAA00CC00) begin
      errors++;
      $display("FAIL strobe_model got %h exp AA00CC00", model[3]);
    end
    do_read(32'h0C, 0);
    do_write(32'h0D, 32'h12345678, 4'h8, 1, 0, 0);
    do_read(32'h0F, 0);
  endtask

  task automatic test_out_of_range();
    do_write(32'h40, 32'hFFFFFFFF, 4'hF, 0, 0, 2);
    do_read(32'h40, 1);
    do_write(32'hFFFF_FFF0, 32'h5A5A5A5A, 4'hF, 2, 1, 0);
    do_read(32'h8000_0004, 0);
    check_all_regs("oor");
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] old_val, new_val;
    do_write(32'h14, 32'h0BADCAFE, 4'hF, 0, 0, 0);
    old_val = model[5];
    new_val = $urandom;
    axi.awaddr = 32'h14; axi.wdata = new_val; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    axi.araddr = 32'h14; axi.arvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    model_write(32'h14, new_val, 4'hF);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({axi.bvalid, axi.rvalid, axi.bresp, axi.rresp, axi.rdata, axi.awready, axi.wready, axi.arready}
          !== {2'b11, 4'b0000, old_val, 3'b000}) begin
        errors++;
        $display("FAIL backpressure cyc %0d got bv %b rv %b bresp %b rresp %b rdata %h rdy %b exp 1 1 00 00 %h 000",
                 i, axi.bvalid, axi.rvalid, axi.bresp, axi.rresp, axi.rdata,
                 {axi.awready, axi.wready, axi.arready}, old_val);
      end
      tick();
    end
    axi.bready = 1'b1; axi.rready = 1'b1;
    tick();
    axi.bready = 1'b0; axi.rready = 1'b0;
    checks++;
    if ({axi.bvalid, axi.rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL concurrent_release got %b exp 00", {axi.bvalid, axi.rvalid});
    end
    do_read(32'h14, 0);
  endtask

  task automatic test_back_to_back();
    int k, cyc, n_req, n_resp;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_v;
    k = 0; cyc = 0;
    axi.bready = 1'b1;
    while (k < 8 && cyc < 40) begin
      if (axi.awready && axi.wready) begin
        axi.awaddr = AW'((k + 8) * 4); axi.wdata = $urandom; axi.wstrb = 4'hF;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        model_write(axi.awaddr, axi.wdata, 4'hF);
        k++;
      end
      tick();
      cyc++;
    end
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    checks++;
    if (cyc !== 15 || k !== 8) begin
      errors++;
      $display("FAIL wr_throughput got %0d writes in %0d cycles exp 8 in 15", k, cyc);
    end
    tick();
    axi.bready = 1'b0;

    n_req = 0; n_resp = 0; cyc = 0;
    axi.rready = 1'b1;
    while (n_resp < 8 && cyc < 40) begin
      if (axi.arready) begin
        if (n_req < 8) begin
          axi.araddr = AW'($urandom_range(0, NR - 1) * 4);
          axi.arvalid = 1'b1;
          exp_q.push_back(model_read(axi.araddr));
          n_req++;
        end else axi.arvalid = 1'b0;
      end
      tick();
      cyc++;
      if (axi.rvalid) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (axi.rdata !== exp_v) begin
          errors++;
          $display("FAIL b2b_rdata got %h exp %h", axi.rdata, exp_v);
        end
        n_resp++;
      end
    end
    axi.arvalid = 1'b0;
    checks++;
    if (cyc !== 15 || n_resp !== 8) begin
      errors++;
      $display("FAIL rd_throughput got %0d reads in %0d cycles exp 8 in 15", n_resp, cyc);
    end
    tick();
    axi.rready = 1'b0;
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int n = 0; n < 40; n++) begin
      a = AW'($urandom_range(0, NR + 3) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0)
        do_write(a, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(a, $urandom_range(0, 3));
    end
    check_all_regs("random");
  endtask

  task automatic test_reset_mid_txn();
    do_write(32'h1C, 32'h77777777, 4'hF, 0, 0, 0);
    axi.awaddr = 32'h1C; axi.awvalid = 1'b1;
    axi.araddr = 32'h1C; axi.arvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0; axi.arvalid = 1'b0;
    checks++;
    if ({axi.awready, axi.wready, axi.rvalid, axi.arready} !== 4'b0110) begin
      errors++;
      $display("FAIL pre_reset_state got %b exp 0110", {axi.awready, axi.wready, axi.rvalid, axi.arready});
    end
    #2;
    aresetn = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    checks++;
    if ({axi.bvalid, axi.rvalid, axi.rdata, axi.awready, axi.wready, axi.arready} !== {2'b00, 32'h0, 3'b111}) begin
      errors++;
      $display("FAIL async_reset got bv %b rv %b rdata %h rdy %b exp 0 0 0 111",
               axi.bvalid, axi.rvalid, axi.rdata, {axi.awready, axi.wready, axi.arready});
    end
    axi.wdata = 32'h99999999; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    repeat (2) tick();
    axi.wvalid = 1'b0;
    aresetn = 1'b1;
    tick();
    checks++;
    if ({axi.bvalid, axi.rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL post_reset_valid got %b exp 00", {axi.bvalid, axi.rvalid});
    end
    check_all_regs("post_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_w_first();
    test_strobe();
    test_out_of_range();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_txn();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
